sseg_arbiter: RTL and testbench

- Shares the single 4-digit seven-segment display driver among N_REQ requesters, e.g. CPU debug, address bus, data bus and monitor.
- Round-robin arbitration with a minimum dwell time, so each owner's value stays visible long enough to read.
- Drives the 16-bit data and 4-bit decimal-point inputs of the display driver from registers.
- Sits between the HITAC-10 core/debug logic and the display driver, in the clk_50M domain.

---
 rtl/sseg_pkg.sv | 24 ++
 rtl/rr_pick.sv | 42 ++++
 rtl/sseg_arbiter.sv | 168 ++++++++++++++++
 tb/tb_sseg_arbiter.sv | 295 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sseg_pkg.sv
// Shared definitions for the seven-segment display arbiter.
// Contents: display geometry constants, the all-points-off decimal-point pattern,
// the arbiter state enum and a helper that builds the owner-marking dp pattern.
package sseg_pkg;

  localparam int unsigned DIGITS  = 4;
  localparam int unsigned DIGIT_W = 4;
  localparam int unsigned DATA_W  = 16;

  // Decimal points are active-low on the display driver.
  localparam logic [DIGITS-1:0] DP_OFF = 4'b1111;

  typedef enum logic [1:0] {
    IDLE,
    HOLD,
    OPEN
  } arb_state_e;

  // Light only the decimal point at position idx (active-low).
  function automatic logic [DIGITS-1:0] owner_dp_mark(input logic [1:0] idx);
    return DP_OFF & ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker.
// Ports:
//   req    - candidate request vector
//   start  - index searched first; the search wraps modulo N
//   onehot - one-hot winner (all zero when nothing is requested)
//   idx    - winner index (0 when nothing is requested)
//   valid  - at least one request is set
module rr_pick #(
  parameter int unsigned N  = 4,
  parameter int unsigned IW = 2
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  output logic [N-1:0]  onehot,
  output logic [IW-1:0] idx,
  output logic          valid
);

  logic [2*N-1:0] dbl;
  logic [N-1:0]   rot;
  int unsigned    sum;

  always_comb begin
    // Rotate so that bit 0 of rot corresponds to requester 'start'.
    dbl   = {req, req} >> start;
    rot   = dbl[N-1:0];
    valid = 1'b0;
    sum   = 0;
    for (int unsigned i = 0; i < N; i++) begin
      if (!valid && rot[i]) begin
        valid = 1'b1;
        sum   = 32'(start) + i;
      end
    end
    if (sum >= N) begin
      sum = sum - N;
    end
    idx    = IW'(sum);
    onehot = valid ? (N'(1) << idx) : '0;
  end

endmodule

// File: rtl/sseg_arbiter.sv
// Round-robin arbiter sharing one 4-digit seven-segment display driver among
// N_REQ requesters, holding each owner for at least DWELL cycles.
// Ports:
//   clk_50M  - system clock
//   reset    - asynchronous active-high reset
//   req      - per-requester level request
//   data_bus - requester k's hex value at [16k+15:16k]
//   dp_bus   - requester k's decimal points at [4k+3:4k]
//   gnt      - registered one-hot grant
//   owner    - index of the current/last owner
//   active   - a grant is held
//   data     - registered data to the display driver
//   dp       - registered decimal points to the display driver
// Build option: define SSEG_ARB_OWNER_DP_EN to replace dp with an owner-index
// marker (dp[owner mod 4] lit, dp_bus ignored, all off when idle).
module sseg_arbiter
  import sseg_pkg::*;
#(
  parameter int unsigned N_REQ = 4,
  parameter int unsigned DWELL = 25_000_000,
  parameter int unsigned CNT_W = $clog2(DWELL)
) (
  input  logic                                    clk_50M,
  input  logic                                    reset,
  input  logic [N_REQ-1:0]                        req,
  input  logic [N_REQ*DATA_W-1:0]                 data_bus,
  input  logic [N_REQ*DIGITS-1:0]                 dp_bus,
  output logic [N_REQ-1:0]                        gnt,
  output logic [((N_REQ > 1) ? $clog2(N_REQ) : 1)-1:0] owner,
  output logic                                    active,
  output logic [DATA_W-1:0]                       data,
  output logic [DIGITS-1:0]                       dp
);

  localparam int unsigned OW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  arb_state_e        state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [OW-1:0]     ptr_q, ptr_d;
  logic [OW-1:0]     owner_q, owner_d;
  logic [N_REQ-1:0]  gnt_q, gnt_d;
  logic              active_q, active_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [DIGITS-1:0] dp_q, dp_d;

  logic [N_REQ-1:0]  cand;
  logic [N_REQ-1:0]  pick_oh;
  logic [OW-1:0]     pick_idx;
  logic              pick_vld;
  logic              owner_req;
  logic              dwell_done;
  logic              take;

  // The owner is excluded so it can only be re-granted through the idle path.
  // Since ptr is always owner+1 while granted, starting at ptr gives
  // "next after the owner" for both switching and drop handling.
  assign cand = req & ~gnt_q;

  rr_pick #(
    .N  (N_REQ),
    .IW (OW)
  ) u_rr_pick (
    .req    (cand),
    .start  (ptr_q),
    .onehot (pick_oh),
    .idx    (pick_idx),
    .valid  (pick_vld)
  );

  assign owner_req  = |(req & gnt_q);
  // The last HOLD cycle already behaves as OPEN, so an owner with contenders
  // keeps the display for exactly DWELL cycles.
  assign dwell_done = (state_q == OPEN) || (cnt_q == CNT_W'(DWELL - 1));

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    ptr_d    = ptr_q;
    owner_d  = owner_q;
    gnt_d    = gnt_q;
    active_d = active_q;
    take     = 1'b0;

    unique case (state_q)
      IDLE: begin
        take = pick_vld;
      end
      HOLD, OPEN: begin
        if (!owner_req) begin
          if (pick_vld) begin
            take = 1'b1;
          end else begin
            state_d  = IDLE;
            gnt_d    = '0;
            active_d = 1'b0;
          end
        end else if (dwell_done) begin
          if (pick_vld) begin
            take = 1'b1;
          end else begin
            state_d = OPEN;
          end
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase

    if (take) begin
      state_d  = HOLD;
      cnt_d    = '0;
      gnt_d    = pick_oh;
      owner_d  = pick_idx;
      active_d = 1'b1;
      ptr_d    = (pick_idx == OW'(N_REQ - 1)) ? '0 : pick_idx + 1'b1;
    end
  end

  // Display registers load the next owner's slice so a new grant and its data
  // appear together; when idle they hold the last value.
  always_comb begin
    data_d = data_q;
    dp_d   = dp_q;
    if (active_d) begin
      for (int k = 0; k < int'(N_REQ); k++) begin
        if (owner_d == OW'(k)) begin
          data_d = data_bus[k*DATA_W +: DATA_W];
`ifndef SSEG_ARB_OWNER_DP_EN
          dp_d   = dp_bus[k*DIGITS +: DIGITS];
`endif
        end
      end
    end
`ifdef SSEG_ARB_OWNER_DP_EN
    dp_d = active_d ? owner_dp_mark(2'(owner_d)) : DP_OFF;
`endif
  end

  always_ff @(posedge clk_50M or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      ptr_q    <= '0;
      owner_q  <= '0;
      gnt_q    <= '0;
      active_q <= 1'b0;
      data_q   <= '0;
      dp_q     <= DP_OFF;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      ptr_q    <= ptr_d;
      owner_q  <= owner_d;
      gnt_q    <= gnt_d;
      active_q <= active_d;
      data_q   <= data_d;
      dp_q     <= dp_d;
    end
  end

  assign gnt    = gnt_q;
  assign owner  = owner_q;
  assign active = active_q;
  assign data   = data_q;
  assign dp     = dp_q;

endmodule

// File: tb/tb_sseg_arbiter.sv
// Self-checking bench for sseg_arbiter (N_REQ=4, DWELL=4) against a
// cycle-count reference model of the round-robin/dwell rules.
module tb_sseg_arbiter;

  localparam int N  = 4;
  localparam int DW = 4;

  logic            clk_50M = 1'b0;
  logic            reset;
  logic [N-1:0]    req;
  logic [N*16-1:0] data_bus;
  logic [N*4-1:0]  dp_bus;
  logic [N-1:0]    gnt;
  logic [1:0]      owner;
  logic            active;
  logic [15:0]     data;
  logic [3:0]      dp;

  int errors = 0;
  int checks = 0;

  // Reference model: owner, whether granted, cycles shown so far, rr pointer.
  int          m_owner;
  int          m_ptr;
  int          m_held;
  bit          m_active;
  logic [15:0] m_data;
  logic [3:0]  m_dp;

  sseg_arbiter #(
    .N_REQ (N),
    .DWELL (DW)
  ) dut (
    .clk_50M  (clk_50M),
    .reset    (reset),
    .req      (req),
    .data_bus (data_bus),
    .dp_bus   (dp_bus),
    .gnt      (gnt),
    .owner    (owner),
    .active   (active),
    .data     (data),
    .dp       (dp)
  );

  always #10 clk_50M = ~clk_50M;

  function automatic logic [15:0] slice16(input int k);
    logic [N*16-1:0] t;
    t = data_bus >> (k * 16);
    return t[15:0];
  endfunction

  function automatic logic [3:0] slice4(input int k);
    logic [N*4-1:0] t;
    t = dp_bus >> (k * 4);
    return t[3:0];
  endfunction

  function automatic int next_after(input int start, input logic [N-1:0] r, input int excl);
    for (int i = 0; i < N; i++) begin
      int k;
      k = (start + i) % N;
      if (r[k] && k != excl) return k;
    end
    return -1;
  endfunction

  function automatic logic [N+2+1+16+4-1:0] expected();
    logic [N-1:0] g;
    g = m_active ? (N'(1) << m_owner) : '0;
    return {g, 2'(m_owner), m_active, m_data, m_dp};
  endfunction

  task automatic model_reset();
    m_owner  = 0;
    m_ptr    = 0;
    m_held   = 0;
    m_active = 0;
    m_data   = 16'h0000;
    m_dp     = 4'b1111;
  endtask

  // Apply the rules to the inputs present just before the coming edge.
  task automatic model_edge();
    int w;
    w = -1;
    if (!m_active) begin
      w = next_after(m_ptr, req, -1);
    end else if (!req[m_owner]) begin
      w = next_after(m_owner + 1, req, m_owner);
      if (w < 0) m_active = 0;
    end else if (m_held >= DW) begin
      w = next_after(m_owner + 1, req, m_owner);
    end
    if (w >= 0) begin
      m_owner  = w;
      m_active = 1;
      m_held   = 1;
      m_ptr    = (w + 1) % N;
    end else if (m_active) begin
      m_held++;
    end
`ifdef SSEG_ARB_OWNER_DP_EN
    m_dp = m_active ? (4'b1111 & ~(4'b0001 << (m_owner % 4))) : 4'b1111;
    if (m_active) m_data = slice16(m_owner);
`else
    if (m_active) begin
      m_data = slice16(m_owner);
      m_dp   = slice4(m_owner);
    end
`endif
  endtask

  task automatic step(input string tag);
    model_edge();
    @(posedge clk_50M);
    #1;
    checks++;
    if ({gnt, owner, active, data, dp} !== expected()) begin
      errors++;
      $display("FAIL %s t=%0t got gnt=%b owner=%0d active=%b data=%h dp=%b want %b",
               tag, $time, gnt, owner, active, data, dp, expected());
    end
  endtask

  task automatic do_reset();
    req   = '0;
    reset = 1'b1;
    @(posedge clk_50M);
    #1;
    reset = 1'b0;
    model_reset();
  endtask

  task automatic test_reset();
    req      = '0;
    data_bus = {$urandom, $urandom};
    dp_bus   = 16'($urandom);
    reset    = 1'b1;
    #5;
    checks++;
    if ({gnt, active, data, dp} !== {4'b0000, 1'b0, 16'h0000, 4'b1111}) begin
      errors++;
      $display("FAIL reset_values got gnt=%b active=%b data=%h dp=%b want 0000 0 0000 1111",
               gnt, active, data, dp);
    end
    @(posedge clk_50M);
    #1;
    reset = 1'b0;
    model_reset();
    for (int i = 0; i < 10; i++) step("reset_idle");
  endtask

  task automatic test_single();
    do_reset();
    data_bus       = {$urandom, $urandom};
    data_bus[15:0] = 16'h1234;
    dp_bus         = 16'($urandom);
    dp_bus[3:0]    = 4'b1110;
    req            = 4'b0001;
    step("single_grant");
    checks++;
    if ({gnt, owner, data} !== {4'b0001, 2'd0, 16'h1234}) begin
      errors++;
      $display("FAIL single_direct got gnt=%b owner=%0d data=%h want 0001 0 1234",
               gnt, owner, data);
    end
    for (int i = 0; i < 8; i++) step("single_hold");
  endtask

  task automatic test_alternate();
    do_reset();
    data_bus = {$urandom, $urandom};
    req      = 4'b0011;
    for (int i = 0; i < 5; i++) step("alt_first");
    checks++;
    if (gnt !== 4'b0010 || data !== data_bus[31:16]) begin
      errors++;
      $display("FAIL alt_switch got gnt=%b data=%h want 0010 %h", gnt, data, data_bus[31:16]);
    end
    for (int i = 0; i < 4; i++) step("alt_back");
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL alt_return got gnt=%b want 0001", gnt);
    end
  endtask

  task automatic test_drop();
    logic [15:0] last2;
    do_reset();
    data_bus = {$urandom, $urandom};
    req      = 4'b0001;
    step("drop_grant0");
    step("drop_cnt1");
    req = 4'b0100;
    step("drop_switch");
    checks++;
    if (gnt !== 4'b0100) begin
      errors++;
      $display("FAIL drop_direct got gnt=%b want 0100", gnt);
    end
    step("drop_hold2");
    last2    = data_bus[47:32];
    req      = 4'b0000;
    step("drop_idle");
    data_bus = {$urandom, $urandom};
    step("drop_idle_hold");
    checks++;
    if (active !== 1'b0 || data !== last2) begin
      errors++;
      $display("FAIL drop_holdval got active=%b data=%h want 0 %h", active, data, last2);
    end
  endtask

  task automatic test_wrap_async();
    do_reset();
    data_bus = {$urandom, $urandom};
    req      = 4'b1000;
    step("wrap_own3");
    req = 4'b1001;
    for (int i = 0; i < 4; i++) step("wrap_hold");
    checks++;
    if (gnt !== 4'b0001) begin
      errors++;
      $display("FAIL wrap_to0 got gnt=%b want 0001", gnt);
    end
    step("wrap_mid_hold");
    #4;
    reset = 1'b1;
    #1;
    checks++;
    if ({gnt, active} !== {4'b0000, 1'b0}) begin
      errors++;
      $display("FAIL async_reset got gnt=%b active=%b want 0000 0", gnt, active);
    end
    req = '0;
    #2;
    reset = 1'b0;
    model_reset();
    step("after_async");
  endtask

`ifdef SSEG_ARB_OWNER_DP_EN
  task automatic test_owner_dp();
    do_reset();
    dp_bus = 16'($urandom);
    req    = 4'b0100;
    step("odp_own2");
    checks++;
    if (dp !== 4'b1011) begin
      errors++;
      $display("FAIL odp_owner2 got dp=%b want 1011", dp);
    end
    req = 4'b0010;
    step("odp_own1");
    checks++;
    if (dp !== 4'b1101) begin
      errors++;
      $display("FAIL odp_owner1 got dp=%b want 1101", dp);
    end
  endtask
`endif

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 600; i++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
      data_bus = {$urandom, $urandom};
      dp_bus   = 16'($urandom);
      step("random");
    end
  endtask

  initial begin
    reset    = 1'b1;
    req      = '0;
    data_bus = '0;
    dp_bus   = '0;
    model_reset();
    test_reset();
    test_single();
    test_alternate();
    test_drop();
    test_wrap_async();
`ifdef SSEG_ARB_OWNER_DP_EN
    test_owner_dp();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
